// File: rtl/digit_serial_pkg.sv
// -----------------------------------------------------------------------------
// digit_serial_pkg
//   Shared types and helpers for the digit-serial adder.
//
//   Contents:
//     dsa_state_t  : control FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//     clog2_min1() : ceil(log2(n)), never less than 1, so that a counter that
//                    only ever needs one value still gets a 1-bit register.
// -----------------------------------------------------------------------------
package digit_serial_pkg;

  typedef enum logic [1:0] {
    DSA_IDLE = 2'd0,
    DSA_RUN  = 2'd1,
    DSA_DONE = 2'd2
  } dsa_state_t;

  // Width of a counter able to hold 0 .. n-1, with a floor of one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : digit_serial_pkg

// File: rtl/dsa_digit_add.sv
// -----------------------------------------------------------------------------
// dsa_digit_add
//   Purely combinational DIGIT-bit ripple-carry adder. This is the only
//   arithmetic between the operand/carry registers and the sum register of
//   digit_serial_adder, so its depth sets the achievable clock rate.
//
//   Parameters:
//     DIGIT : number of bits added (>= 1)
//
//   Ports:
//     x  in  [DIGIT-1:0]  addend digit
//     y  in  [DIGIT-1:0]  addend digit
//     ci in  1            carry in
//     s  out [DIGIT-1:0]  sum digit
//     co out 1            carry out of the top bit
// -----------------------------------------------------------------------------
module dsa_digit_add #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // c[i] is the carry into bit i; c[DIGIT] is the carry out of the digit.
  logic [DIGIT:0] c;

  assign c[0] = ci;

  // Explicit full-adder chain keeps the structure a plain ripple.
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y[gi]) | (x[gi] & c[gi]) | (y[gi] & c[gi]);
  end

  assign co = c[DIGIT];

endmodule : dsa_digit_add

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle unsigned adder. A WIDTH-bit add is carried out DIGIT bits per
//   clock, least significant digit first, with the inter-digit carry held in a
//   register. Only a DIGIT-bit ripple chain lies between registers.
//
//   Handshake: operands are taken on in_valid && in_ready (in_ready only in
//   IDLE). out_valid rises exactly NDIG cycles after the accept edge and the
//   result is held until out_valid && out_ready. After that handoff edge the
//   block returns to IDLE, so one operation occupies at least NDIG+2 cycles.
//
//   Parameters:
//     WIDTH : operand / sum width (>= 1)
//     DIGIT : bits added per cycle, 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
//
//   Ports:
//     clk       in   1      clock, rising edge
//     rst       in   1      synchronous reset, active high
//     in_valid  in   1      a, b, cin (and sub) present
//     in_ready  out  1      operands can be accepted
//     a         in   WIDTH  operand A
//     b         in   WIDTH  operand B
//     cin       in   1      carry in
//     sub       in   1      (DSA_SUB_EN only) subtract: a + ~b + (cin ^ sub)
//     out_valid out  1      sum / cout valid
//     out_ready in   1      consumer accepts the result
//     sum       out  WIDTH  registered result
//     cout      out  1      registered carry out of the MSB digit
//
//   Build option:
//     DSA_SUB_EN : when defined, adds the sub input. cout=1 then means
//                  "no borrow". Latency is unchanged.
// -----------------------------------------------------------------------------
module digit_serial_adder
  import digit_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IW   = clog2_min1(NDIG);

  // Reject illegal geometries while elaborating rather than building
  // something that silently drops the top bits.
  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
    $error("digit_serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0 (WIDTH=%0d DIGIT=%0d)",
           WIDTH, DIGIT);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  dsa_state_t       state_q, state_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic [WIDTH-1:0] opa_q,   opa_d;
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time. Subtraction is folded into the
  // latched B operand and the initial carry so the datapath only ever adds.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_in;
  logic             carry_in;

`ifdef DSA_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = cin ^ sub;
`else
  assign b_in     = b;
  assign carry_in = cin;
`endif

  // ---------------------------------------------------------------------------
  // Digit datapath: one DIGIT-wide slice selected by idx_q.
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] dig_x;
  logic [DIGIT-1:0] dig_y;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             last_digit;

  assign dig_x = opa_q[idx_q*DIGIT +: DIGIT];
  assign dig_y = opb_q[idx_q*DIGIT +: DIGIT];

  dsa_digit_add #(
    .DIGIT (DIGIT)
  ) u_digit_add (
    .x  (dig_x),
    .y  (dig_y),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  assign last_digit = (idx_q == IW'(NDIG - 1));

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      DSA_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b_in;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = DSA_RUN;
        end
      end

      DSA_RUN: begin
        // Upper sum digits still hold the previous result here; each one is
        // overwritten before DONE, so they are never cleared on accept.
        sum_d[idx_q*DIGIT +: DIGIT] = dig_s;
        carry_d = dig_co;
        if (last_digit) begin
          cout_d  = dig_co;
          idx_d   = '0;
          state_d = DSA_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DSA_DONE: begin
        if (out_ready) begin
          state_d = DSA_IDLE;
        end
      end

      default: begin
        state_d = DSA_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset takes priority over any handshake in the same cycle, so
  // an in-flight operation is simply dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DSA_IDLE;
      idx_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake flags come straight from the state register: no combinational
  // path from any input to in_ready or out_valid.
  assign in_ready  = (state_q == DSA_IDLE);
  assign out_valid = (state_q == DSA_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : digit_serial_adder

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//   Self-checking bench for digit_serial_adder at WIDTH=32, DIGIT=4 (NDIG=8).
//   A vector table of hand-computed sums is applied through the handshake,
//   followed by hand-written sequences for stall, reset and random ops.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_digit_serial_adder;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef DSA_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef DSA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation through the handshake. With noise set, in_valid is
  // held high with other operands during RUN/DONE to show they are ignored.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tcin,
                        input int stall, input bit noise,
                        output logic [31:0] rs, output logic rc, output int lat);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    a = ta; b = tb_v; cin = tcin; in_valid = 1'b1;
    tick();
    in_valid = noise;
    a = ~ta; b = ta ^ 32'h5A5A5A5A; cin = ~tcin;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    rs = sum;
    rc = cout;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_sum", 64'(sum), 64'(rs));
      chk("stall_cout", 64'(cout), 64'(rc));
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    chk("in_ready_done", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] rs;
    logic        rc;
    int          lat;
    logic [32:0] ref_v;
    logic [31:0] ra, rb;
    logic        rci;
    bit          seen;

    vecs[0]  = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[2]  = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0};
    vecs[3]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[7]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};
    vecs[9]  = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
    vecs[10] = '{32'hDEADBEEF, 32'h00000001, 1'b0, 32'hDEADBEF0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef DSA_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, (i == 2) ? 5 : 0, (i == 2), rs, rc, lat);
      $display("[TB] vec %0d a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat);
      chk("vec_sum", 64'(rs), 64'(vecs[i].s));
      chk("vec_cout", 64'(rc), 64'(vecs[i].co));
      chk("vec_latency", 64'(lat), 64'(NDIG));
    end

    // Reset in the middle of RUN (idx==3): op dropped, reset state next cycle
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_sum", 64'(sum), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrun_rst_no_pulse", 64'(seen), 64'd0);
    run_op(32'd1, 32'd1, 1'b0, 0, 1'b0, rs, rc, lat);
    $display("[TB] after reset 1+1 -> sum=%h cout=%0d lat=%0d", rs, rc, lat);
    chk("after_rst_sum", 64'(rs), 64'd2);
    chk("after_rst_lat", 64'(lat), 64'(NDIG));

    // Reset in DONE: result discarded
    a = 32'd9; b = 32'd9; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NDIG + 1; i++) tick();
    chk("done_before_rst", 64'(out_valid), 64'd1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("done_rst_out_valid", 64'(out_valid), 64'd0);
    chk("done_rst_sum", 64'(sum), 64'd0);
    $display("[TB] reset in DONE -> out_valid=%0d sum=%h", out_valid, sum);

    // rst together with in_valid: nothing accepted
    a = 32'd3; b = 32'd4; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NDIG + 2; i++) begin
      tick();
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("rst_with_valid_ignored", 64'(seen), 64'd0);
    $display("[TB] rst with in_valid -> accepted=%0d", seen);

    // Random operations against a 33-bit reference sum
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom_range(0, 1));
      ref_v = 33'(ra) + 33'(rb) + 33'(rci);
      run_op(ra, rb, rci, int'($urandom_range(0, 2)), 1'b0, rs, rc, lat);
      $display("[TB] rnd %0d a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", i, ra, rb, rci, rs, rc, lat);
      chk("rnd_result", 64'({rc, rs}), 64'(ref_v));
      chk("rnd_latency", 64'(lat), 64'(NDIG));
    end

`ifdef DSA_SUB_EN
    sub = 1'b1;
    run_op(32'd5, 32'd7, 1'b0, 0, 1'b0, rs, rc, lat);
    $display("[TB] sub 5-7 -> sum=%h cout=%0d", rs, rc);
    chk("sub_5_7_sum", 64'(rs), 64'hFFFFFFFE);
    chk("sub_5_7_cout", 64'(rc), 64'd0);
    run_op(32'd7, 32'd5, 1'b0, 0, 1'b0, rs, rc, lat);
    $display("[TB] sub 7-5 -> sum=%h cout=%0d", rs, rc);
    chk("sub_7_5_sum", 64'(rs), 64'd2);
    chk("sub_7_5_cout", 64'(rc), 64'd1);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_digit_serial_adder
